// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/MEM requesters, the memory port arbiter and the
// unified single-port BRAM.
//
// Signals
//   IReq/IAddr/IFlush      IF read request, byte address, response flush
//   IValid/IRdata          IF response pulse and instruction word
//   DReq/DWe/DAddr/DWdata  MEM request, byte write enables (0 = read),
//                          byte address, lane-aligned store data
//   DValid/DRdata          MEM response/write-done pulse and load data
//   RamEn/RamWe/RamAddr/RamWdata  BRAM command (driven by the arbiter)
//   RamRdata               BRAM read data, one cycle after RamEn
//
// Modports
//   slave   the arbiter
//   master  the environment: requesters plus the BRAM read-data return
interface mem_port_arbiter_if #(
  parameter int RAM_AW = 12
);
  logic              IReq;
  logic [31:0]       IAddr;
  logic              IFlush;
  logic              IValid;
  logic [31:0]       IRdata;
  logic              DReq;
  logic [3:0]        DWe;
  logic [31:0]       DAddr;
  logic [31:0]       DWdata;
  logic              DValid;
  logic [31:0]       DRdata;
  logic              RamEn;
  logic [3:0]        RamWe;
  logic [RAM_AW-1:0] RamAddr;
  logic [31:0]       RamWdata;
  logic [31:0]       RamRdata;

  modport slave (
    input  IReq, IAddr, IFlush, DReq, DWe, DAddr, DWdata, RamRdata,
    output IValid, IRdata, DValid, DRdata, RamEn, RamWe, RamAddr, RamWdata
  );

  modport master (
    output IReq, IAddr, IFlush, DReq, DWe, DAddr, DWdata, RamRdata,
    input  IValid, IRdata, DValid, DRdata, RamEn, RamWe, RamAddr, RamWdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one single-port, 1-cycle-latency BRAM between
// instruction fetch (IF) and data access (MEM).
//
// Ports
//   clk    clock, all state updates on the rising edge
//   rst_n  synchronous active-low reset
//   bus    mem_port_arbiter_if.slave: IF/MEM request and response signals
//          plus the BRAM command/read-data signals
//
// Operation
//   Each cycle one requester is granted combinationally and drives the BRAM.
//   MEM has priority; IF wins when MEM is idle or after IF has lost
//   arbitration STARVE_MAX consecutive cycles. The granted side is recorded
//   in a pending register and its response valid pulses the following cycle.
module mem_port_arbiter #(
  parameter int RAM_AW     = 12,
  parameter int STARVE_MAX = 4
) (
  input logic                clk,
  input logic                rst_n,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,
    PEND_I    = 2'd1,
    PEND_D    = 2'd2
  } pend_e;

  pend_e       pend_q, pend_d;
  logic [3:0]  starve_q, starve_d;
  logic        gnt_i, gnt_d;

  // Only the word-address field reaches the BRAM; the rest is ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.IAddr[31:RAM_AW+2], bus.IAddr[1:0],
                              bus.DAddr[31:RAM_AW+2], bus.DAddr[1:0]};

  // Grant: held inactive while reset is asserted so no BRAM write can slip
  // through during reset.
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (rst_n) begin
      if (bus.DReq && !(bus.IReq && (starve_q == STARVE_LIM))) begin
        gnt_d = 1'b1;
      end else if (bus.IReq) begin
        gnt_i = 1'b1;
      end
    end
  end

  always_comb begin
    bus.RamEn    = gnt_i | gnt_d;
    bus.RamWe    = 4'b0000;
    bus.RamAddr  = '0;
    bus.RamWdata = 32'd0;
    if (gnt_d) begin
      bus.RamWe    = bus.DWe;
      bus.RamAddr  = bus.DAddr[RAM_AW+1:2];
      bus.RamWdata = bus.DWdata;
    end else if (gnt_i) begin
      bus.RamAddr  = bus.IAddr[RAM_AW+1:2];
    end
  end

  // Next-state: pending owner follows the grant; the starvation count only
  // grows while IF is actually waiting behind a MEM grant.
  always_comb begin
    pend_d   = PEND_NONE;
    starve_d = starve_q;
    if (gnt_d) begin
      pend_d = PEND_D;
    end else if (gnt_i) begin
      pend_d = PEND_I;
    end

    if (!bus.IReq || gnt_i) begin
      starve_d = 4'd0;
    end else if (gnt_d && (starve_q < STARVE_LIM)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q   <= PEND_NONE;
      starve_q <= 4'd0;
    end else begin
      pend_q   <= pend_d;
      starve_q <= starve_d;
    end
  end

  // Responses: read data is passed straight through from the BRAM. A flush
  // only masks the IF valid of the response arriving this cycle.
  always_comb begin
    bus.IValid = (pend_q == PEND_I) && !bus.IFlush;
    bus.DValid = (pend_q == PEND_D);
    bus.IRdata = bus.RamRdata;
    bus.DRdata = bus.RamRdata;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int RAM_AW     = 12;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.RAM_AW(RAM_AW)) bus ();

  mem_port_arbiter #(.RAM_AW(RAM_AW), .STARVE_MAX(STARVE_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural write-first BRAM driven by the DUT's command outputs.
  logic [31:0] bram [0:4095];
  logic [31:0] bram_rd;
  always @(posedge clk) begin : bram_proc
    logic [31:0] w;
    if (bus.RamEn) begin
      w = bram[bus.RamAddr];
      for (int b = 0; b < 4; b++)
        if (bus.RamWe[b]) w[8*b +: 8] = bus.RamWdata[8*b +: 8];
      bram[bus.RamAddr] <= w;
      bram_rd <= w;
    end
  end
  assign bus.RamRdata = bram_rd;

  // Reference model state: memory image, pending response owner
  // (0 none, 1 IF, 2 MEM), the data that response must carry, and the
  // count of consecutive cycles IF has lost to MEM.
  logic [31:0] ref_mem [0:4095];
  int          m_pend;
  int          m_starve;
  logic [31:0] m_rdata;
  logic        m_dread;
  int          obs_gnt;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare all outputs against the model,
  // then advance the model.
  task automatic step(input logic rst, input logic ireq, input logic [31:0] iaddr,
                      input logic iflush, input logic dreq, input logic [3:0] dwe,
                      input logic [31:0] daddr, input logic [31:0] dwdata);
    int g;
    int wa;
    logic [31:0] w;
    @(posedge clk);
    #1;
    rst_n      = rst;
    bus.IReq   = ireq;
    bus.IAddr  = iaddr;
    bus.IFlush = iflush;
    bus.DReq   = dreq;
    bus.DWe    = dwe;
    bus.DAddr  = daddr;
    bus.DWdata = dwdata;
    #3;
    g = 0;
    if (rst) begin
      if (dreq && !(ireq && m_starve == STARVE_MAX)) g = 2;
      else if (ireq) g = 1;
    end
    wa = (g == 2) ? int'(daddr[13:2]) : int'(iaddr[13:2]);
    check("RamEn",    32'(bus.RamEn),   32'(g != 0));
    check("RamWe",    32'(bus.RamWe),   (g == 2) ? 32'(dwe) : 32'd0);
    check("RamAddr",  32'(bus.RamAddr), (g != 0) ? 32'(wa) : 32'd0);
    check("RamWdata", bus.RamWdata,     (g == 2) ? dwdata : 32'd0);
    check("IValid",   32'(bus.IValid),  32'(m_pend == 1 && !iflush));
    check("DValid",   32'(bus.DValid),  32'(m_pend == 2));
    if (m_pend == 1 && !iflush) check("IRdata", bus.IRdata, m_rdata);
    if (m_pend == 2 && m_dread) check("DRdata", bus.DRdata, m_rdata);
    obs_gnt = !bus.RamEn ? 0 : ((32'(bus.RamAddr) == 32'(iaddr[13:2])) ? 1 : 2);
    if (!rst) begin
      m_pend   = 0;
      m_starve = 0;
    end else begin
      if (g != 0) begin
        w = ref_mem[wa];
        if (g == 2)
          for (int b = 0; b < 4; b++)
            if (dwe[b]) w[8*b +: 8] = dwdata[8*b +: 8];
        ref_mem[wa] = w;
        m_rdata = w;
        m_dread = (g == 2) && (dwe == 4'b0000);
      end
      m_pend = g;
      if (!ireq || g == 1) m_starve = 0;
      else if (g == 2 && m_starve < STARVE_MAX) m_starve++;
    end
  endtask

  int pat [10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

  initial begin
    logic        ci, cd, cf, cr;
    logic [31:0] ia, da, dw, r;
    logic [3:0]  we;

    for (int i = 0; i < 4096; i++) begin
      r = $urandom;
      bram[i]    = r;
      ref_mem[i] = r;
    end
    bram[4]    = 32'h00500093;  ref_mem[4] = 32'h00500093;
    bram[8]    = 32'h11223344;  ref_mem[8] = 32'h11223344;
    m_pend = 0; m_starve = 0; m_rdata = 32'd0; m_dread = 1'b0; obs_gnt = 0;
    rst_n = 1'b0;
    bus.IReq = 1'b0; bus.IAddr = 32'd0; bus.IFlush = 1'b0;
    bus.DReq = 1'b0; bus.DWe = 4'd0; bus.DAddr = 32'd0; bus.DWdata = 32'd0;
    @(posedge clk);

    // Reset held with both requesting, then first grant goes to MEM
    repeat (3) step(0, 1, 32'h10, 0, 1, 4'd0, 32'h40, 32'd0);
    check("rst_ramen", 32'(bus.RamEn), 32'd0);
    step(1, 1, 32'h10, 0, 1, 4'd0, 32'h40, 32'd0);
    check("rst_first_gnt", 32'(obs_gnt), 32'd2);
    step(1, 0, 32'd0, 0, 0, 4'd0, 32'd0, 32'd0);

    // IF only, back-to-back fetches
    for (int c = 0; c < 6; c++) begin
      step(1, 1, 32'h10, 0, 0, 4'd0, 32'd0, 32'd0);
      if (c >= 1) begin
        check("ifonly_valid", 32'(bus.IValid), 32'd1);
        check("ifonly_data", bus.IRdata, 32'h00500093);
      end
    end
    step(1, 0, 32'd0, 0, 0, 4'd0, 32'd0, 32'd0);

    // Partial store then load; full store then write-first readback; aliasing
    step(1, 0, 32'd0, 0, 1, 4'b0011, 32'h20, 32'hAABBCCDD);
    step(1, 0, 32'd0, 0, 1, 4'b0000, 32'h20, 32'hAABBCCDD);
    check("st_done", 32'(bus.DValid), 32'd1);
    step(1, 0, 32'd0, 0, 0, 4'd0, 32'd0, 32'd0);
    check("ld_data", bus.DRdata, 32'h1122CCDD);
    step(1, 0, 32'd0, 0, 1, 4'hF, 32'h24, 32'hCAFEF00D);
    step(1, 0, 32'd0, 0, 1, 4'h0, 32'h24, 32'd0);
    step(1, 0, 32'd0, 0, 1, 4'h0, 32'hFFFFC026, 32'd0);
    check("wf_data", bus.DRdata, 32'hCAFEF00D);
    step(1, 0, 32'd0, 0, 0, 4'd0, 32'd0, 32'd0);
    check("alias_data", bus.DRdata, 32'hCAFEF00D);

    // Starvation bound with both held high
    for (int c = 0; c < 10; c++) begin
      step(1, 1, 32'h10, 0, 1, 4'd0, 32'h40, 32'd0);
      check($sformatf("starve_gnt%0d", c), 32'(obs_gnt), 32'(pat[c]));
    end
    step(1, 0, 32'd0, 0, 0, 4'd0, 32'd0, 32'd0);

    // Flush drops only the response arriving in the flush cycle
    step(1, 1, 32'h30, 0, 0, 4'd0, 32'd0, 32'd0);
    step(1, 1, 32'h30, 1, 0, 4'd0, 32'd0, 32'd0);
    check("flush_drop", 32'(bus.IValid), 32'd0);
    step(1, 0, 32'd0, 0, 0, 4'd0, 32'd0, 32'd0);
    check("flush_next", 32'(bus.IValid), 32'd1);

    // Reset in the middle of a MEM read, then re-issue
    step(1, 0, 32'd0, 0, 1, 4'd0, 32'h20, 32'd0);
    step(0, 0, 32'd0, 0, 1, 4'd0, 32'h20, 32'd0);
    check("rstmid_en", 32'(bus.RamEn), 32'd0);
    step(1, 0, 32'd0, 0, 1, 4'd0, 32'h20, 32'd0);
    check("rstmid_dvalid", 32'(bus.DValid), 32'd0);
    step(1, 0, 32'd0, 0, 0, 4'd0, 32'd0, 32'd0);
    check("reissue_valid", 32'(bus.DValid), 32'd1);
    check("reissue_data", bus.DRdata, 32'h1122CCDD);

    // Random traffic obeying the hold-until-valid protocol
    ci = 1'b0; cd = 1'b0; ia = 32'd0; da = 32'd0; dw = 32'd0; we = 4'd0;
    for (int n = 0; n < 3000; n++) begin
      if (!ci || m_pend == 1) begin
        ci = ($urandom_range(0, 3) != 0);
        r  = $urandom;
        ia = {r[31:14], 12'($urandom_range(0, 15)), r[1:0]};
      end
      if (!cd || m_pend == 2) begin
        cd = ($urandom_range(0, 2) != 0);
        r  = $urandom;
        da = {r[31:14], 12'($urandom_range(0, 15)), r[1:0]};
        dw = $urandom;
        we = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'd0;
      end
      cf = ($urandom_range(0, 3) == 0);
      cr = ($urandom_range(0, 49) != 0);
      step(cr, ci, ia, cf, cd, we, da, dw);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
